// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared frame-state type and PS/2 scan-code constants
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] KEY_START  = 8'h5A;
    localparam logic [7:0] KEY_RED    = 8'h2D;
    localparam logic [7:0] KEY_GREEN  = 8'h34;
    localparam logic [7:0] KEY_BLUE   = 8'h32;
    localparam logic [7:0] KEY_YELLOW = 8'h35;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset value lets the bus read as idle out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard frame receiver with make/break decoding
module ps2_rx
    import simon_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       btn_pulse,
    output logic [7:0] btn_code,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic            clk_s;
    logic            data_s;
    logic            clk_prev;
    logic            fall;

    frame_state_t    state_q;
    frame_state_t    state_d;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [WD_W-1:0] wd_q;

    logic            break_pend;
    logic            ext_pend;
    logic [7:0]      held_code;

    logic            timeout;
    logic            accept;
    logic            err_d;
    logic            pulse_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_clk (
        .clk (clk),
        .rst (rst),
        .d   (ps2_clk),
        .q   (clk_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (ps2_data),
        .q   (data_s)
    );

    // Delayed copy of the synchronized PS/2 clock for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s;
        end
    end

    assign fall = clk_prev & ~clk_s;

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the accept/error decisions made on the deciding edge
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_d   = 1'b0;
        timeout = (state_q != ST_IDLE) && !fall && (wd_q == WD_W'(TIMEOUT_CYC - 1));
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && (^{shift_q, par_q})) begin
                        accept = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A make code only strobes when it is new; prefixes, releases and repeats are silent
    assign pulse_d = accept && (shift_q != BREAK_CODE) && !break_pend &&
                     (shift_q != EXT_CODE) && (shift_q != held_code);

    // Bit counter, shift register, parity capture and idle watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            if (fall || timeout || state_q == ST_IDLE) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (fall && !timeout) begin
                unique case (state_q)
                    ST_IDLE:   bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shift_q <= {data_s, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_q <= data_s;
                    default:   ;
                endcase
            end
        end
    end

    // Scan-code decoding and the registered one-cycle strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_pulse  <= 1'b0;
            frame_err  <= 1'b0;
            btn_code   <= 8'h00;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            held_code  <= 8'h00;
        end else begin
            btn_pulse <= pulse_d;
            frame_err <= err_d;
            if (accept) begin
                if (shift_q == BREAK_CODE) begin
                    break_pend <= 1'b1;
                end else if (break_pend) begin
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                    if (shift_q == held_code) begin
                        held_code <= 8'h00;
                    end
                end else if (shift_q == EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    if (shift_q != held_code) begin
                        btn_code  <= shift_q;
                        held_code <= shift_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed table-driven bench for ps2_rx
module tb_ps2_rx;
    import simon_pkg::*;

    localparam int T    = 40;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       btn_pulse;
    logic [7:0] btn_code;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int err_cnt = 0;
    int pulse_cyc = 0;
    int err_cyc = 0;
    int last_fall_cyc = 0;
    logic       prev_pulse = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] prev_code = 8'h00;

    typedef struct {
        logic [7:0] data;
        bit         par_bad;
        bit         stop_bad;
        int         pulses;
        int         errs;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } vec_t;

    vec_t vecs[12];

    ps2_rx #(.TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .btn_pulse (btn_pulse),
        .btn_code  (btn_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe bookkeeping and the per-cycle output invariants
    always @(negedge clk) begin
        if (!rst) begin
            if (btn_pulse) begin
                pulse_cnt++;
                pulse_cyc = cyc;
                chk("pulse_excl_err", int'(frame_err), 0);
                chk("pulse_width", int'(prev_pulse), 0);
            end
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
                chk("err_width", int'(prev_err), 0);
            end
            if (btn_code != prev_code) begin
                chk("code_change_with_pulse", int'(btn_pulse), 1);
            end
        end
        prev_pulse = btn_pulse;
        prev_err   = frame_err;
        prev_code  = btn_code;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic par;
        par = (~^d) ^ par_bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(!stop_bad);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    initial begin
        int p0;
        int e0;
        int n;

        vecs[0]  = '{8'h5A, 1'b0, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b0};
        vecs[1]  = '{8'h2D, 1'b0, 1'b0, 1, 0, 8'h2D, 1'b0, 1'b0};
        vecs[2]  = '{8'h2D, 1'b0, 1'b0, 0, 0, 8'h2D, 1'b0, 1'b0};
        vecs[3]  = '{8'h2D, 1'b0, 1'b0, 0, 0, 8'h2D, 1'b0, 1'b0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h2D, 1'b1, 1'b0};
        vecs[5]  = '{8'h2D, 1'b0, 1'b0, 0, 0, 8'h2D, 1'b0, 1'b0};
        vecs[6]  = '{8'h2D, 1'b0, 1'b0, 1, 0, 8'h2D, 1'b0, 1'b0};
        vecs[7]  = '{8'h34, 1'b1, 1'b0, 0, 1, 8'h2D, 1'b0, 1'b0};
        vecs[8]  = '{8'h34, 1'b0, 1'b1, 0, 1, 8'h2D, 1'b0, 1'b0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h2D, 1'b0, 1'b1};
        vecs[10] = '{8'h35, 1'b0, 1'b0, 1, 0, 8'h35, 1'b0, 1'b0};
        vecs[11] = '{8'h35, 1'b0, 1'b0, 0, 0, 8'h35, 1'b0, 1'b0};

        // Reset values
        wait_cyc(4);
        chk("rst_pulse", int'(btn_pulse), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_code", int'(btn_code), 0);
        rst = 1'b0;
        wait_cyc(10);
        chk("no_false_edge_err", err_cnt, 0);

        // Table of complete frames; strobes land 3 cycles after the PS/2 clock drop
        // (two synchronizer flops, then the registered strobe off the detect cycle)
        for (int i = 0; i < 12; i++) begin
            p0 = pulse_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop_bad);
            chk($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].pulses);
            chk($sformatf("v%0d_errs", i), err_cnt - e0, vecs[i].errs);
            chk($sformatf("v%0d_code", i), int'(btn_code), int'(vecs[i].code));
            chk($sformatf("v%0d_break_pend", i), int'(dut.break_pend), int'(vecs[i].brk));
            chk($sformatf("v%0d_ext_pend", i), int'(dut.ext_pend), int'(vecs[i].ext));
            if (vecs[i].pulses == 1)
                chk($sformatf("v%0d_pulse_lat", i), pulse_cyc - last_fall_cyc, 3);
            if (vecs[i].errs == 1)
                chk($sformatf("v%0d_err_lat", i), err_cyc - last_fall_cyc, 3);
        end

        // Bad start bit: a lone falling edge with data high
        p0 = pulse_cnt;
        e0 = err_cnt;
        send_bit(1'b1);
        wait_cyc(10);
        chk("badstart_err", err_cnt - e0, 1);
        chk("badstart_pulse", pulse_cnt - p0, 0);
        chk("badstart_lat", err_cyc - last_fall_cyc, 3);

        // Timeout after start + 4 data bits
        p0 = pulse_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        n = 0;
        while (err_cnt == e0 && n < 200) begin
            wait_cyc(1);
            n++;
        end
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_lat", err_cyc - last_fall_cyc, T + 3);
        chk("timeout_pulse", pulse_cnt - p0, 0);
        chk("timeout_state", int'(dut.state_q), int'(ST_IDLE));
        wait_cyc(5);
        p0 = pulse_cnt;
        send_frame(8'h32, 1'b0, 1'b0);
        chk("after_timeout_pulse", pulse_cnt - p0, 1);
        chk("after_timeout_code", int'(btn_code), 8'h32);

        // Reset mid-frame
        p0 = pulse_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        wait_cyc(3);
        chk("midrst_pulse", int'(btn_pulse), 0);
        chk("midrst_err", int'(frame_err), 0);
        chk("midrst_code", int'(btn_code), 0);
        chk("midrst_state", int'(dut.state_q), int'(ST_IDLE));
        chk("midrst_break", int'(dut.break_pend), 0);
        chk("midrst_ext", int'(dut.ext_pend), 0);
        chk("midrst_held", int'(dut.held_code), 0);
        rst = 1'b0;
        wait_cyc(3 * T);
        chk("postrst_pulse", pulse_cnt - p0, 0);
        chk("postrst_err", err_cnt - e0, 0);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("postrst_frame_pulse", pulse_cnt - p0, 1);
        chk("postrst_frame_code", int'(btn_code), 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
